// File: rtl/cpu_types_pkg.sv
// Shared types for the data cache: word/address widths, FSM states and
// the address-split record. Field widths here are upper bounds; the cache
// narrows them from its own SETS/BLKWORDS parameters.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FETCH,
        FLUSH,
        DONE
    } dstate_t;

    // Widest split the cache supports (SETS<=256, BLKWORDS<=8)
    typedef struct packed {
        logic [ADDR_W-1:0] tag;
        logic [7:0]        idx;
        logic [2:0]        woff;
        logic [1:0]        boff;
    } dcachef_t;

endpackage

// File: rtl/dcache_way_array.sv
// One way of the data cache: tag, valid, dirty and block data per set.
// Single write port (metadata and/or one data word), asynchronous read at
// the same index/word.
module dcache_way_array
    import cpu_types_pkg::*;
#(
    parameter int SETS     = 8,
    parameter int BLKWORDS = 2,
    parameter int TAG_W    = 26,
    parameter int IDX_W    = 3,
    parameter int WOFF_W   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WOFF_W-1:0] word_i,
    input  logic              we_data_i,
    input  word_t             wdata_i,
    input  logic              we_meta_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic              valid_i,
    input  logic              dirty_i,
    output logic [TAG_W-1:0]  tag_o,
    output logic              valid_o,
    output logic              dirty_o,
    output word_t             rdata_o
);

    logic [TAG_W-1:0] tag_q  [SETS];
    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;
    word_t            data_q [SETS][BLKWORDS];

    // Status bits: cleared by reset, otherwise written with the tag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_meta_i) begin
            valid_q[idx_i] <= valid_i;
            dirty_q[idx_i] <= dirty_i;
        end
    end

    // Tag and data storage; contents are meaningless while valid is clear
    always_ff @(posedge clk_i) begin
        if (we_meta_i) tag_q[idx_i] <= tag_i;
        if (we_data_i) data_q[idx_i][word_i] <= wdata_i;
    end

    assign tag_o   = tag_q[idx_i];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign rdata_o = data_q[idx_i][word_i];

endmodule

// File: rtl/wb_dcache.sv
// 2-way set-associative write-back data cache with LRU replacement,
// word-serial write-back/fetch to memory and a halt-triggered flush.
module wb_dcache
    import cpu_types_pkg::*;
#(
    parameter int SETS     = 8,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    input  logic        halt,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);

    localparam int WOFF_BITS = $clog2(BLKWORDS);
    localparam int WOFF_W    = (WOFF_BITS > 0) ? WOFF_BITS : 1;
    localparam int IDX_W     = $clog2(SETS);
    localparam int TAG_LSB   = 2 + WOFF_BITS + IDX_W;
    localparam int TAG_W     = ADDR_W - TAG_LSB;

    function automatic dcachef_t split_addr(input logic [31:0] a);
        dcachef_t s;
        s.boff = a[1:0];
        s.woff = 3'((a >> 2) & 32'(BLKWORDS - 1));
        s.idx  = 8'((a >> (2 + WOFF_BITS)) & 32'(SETS - 1));
        s.tag  = a >> TAG_LSB;
        return s;
    endfunction

    function automatic logic [31:0] blk_addr(input logic [TAG_W-1:0] t,
                                             input logic [IDX_W-1:0] i,
                                             input logic [WOFF_W-1:0] c);
        return (32'(t) << TAG_LSB) | (32'(i) << (2 + WOFF_BITS)) | (32'(c) << 2);
    endfunction

    dcachef_t          req;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WOFF_W-1:0] req_woff;
    logic              unused_req;

    assign req        = split_addr(dmemaddr);
    assign req_tag    = req.tag[TAG_W-1:0];
    assign req_idx    = req.idx[IDX_W-1:0];
    assign req_woff   = req.woff[WOFF_W-1:0];
    assign unused_req = ^req;

    dstate_t           state_q, state_d;
    logic [WOFF_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              way_q, way_d;
    logic              flush_q, flush_d;
    logic [SETS-1:0]   lru_q, lru_d;

    // Way array ports (shared index/word/write data, per-way enables)
    logic [IDX_W-1:0]              arr_idx;
    logic [WOFF_W-1:0]             arr_word;
    logic [1:0]                    we_data, we_meta;
    word_t                         wdata;
    logic [TAG_W-1:0]              wtag;
    logic                          wvalid, wdirty;
    logic [1:0][TAG_W-1:0]         tag_w;
    logic [1:0]                    valid_w, dirty_w;
    logic [1:0][WORD_W-1:0]        rdata_w;

    // Outside IDLE the set is held in idx_q and the word walks with cnt_q
    assign arr_idx  = (state_q == IDLE) ? req_idx  : idx_q;
    assign arr_word = (state_q == IDLE) ? req_woff : cnt_q;

    for (genvar w = 0; w < 2; w++) begin : g_way
        dcache_way_array #(
            .SETS(SETS), .BLKWORDS(BLKWORDS),
            .TAG_W(TAG_W), .IDX_W(IDX_W), .WOFF_W(WOFF_W)
        ) u_way (
            .clk_i    (CLK),
            .rst_i    (RST),
            .idx_i    (arr_idx),
            .word_i   (arr_word),
            .we_data_i(we_data[w]),
            .wdata_i  (wdata),
            .we_meta_i(we_meta[w]),
            .tag_i    (wtag),
            .valid_i  (wvalid),
            .dirty_i  (wdirty),
            .tag_o    (tag_w[w]),
            .valid_o  (valid_w[w]),
            .dirty_o  (dirty_w[w]),
            .rdata_o  (rdata_w[w])
        );
    end

    logic hit0, hit1, hit_any, hit_way, req_any, victim, last_word;

    assign hit0      = valid_w[0] && (tag_w[0] == req_tag);
    assign hit1      = valid_w[1] && (tag_w[1] == req_tag);
    assign hit_any   = hit0 || hit1;
    assign hit_way   = hit1;
    assign req_any   = dmemREN || dmemWEN;
    assign victim    = !valid_w[0] ? 1'b0 : (!valid_w[1] ? 1'b1 : lru_q[req_idx]);
    assign last_word = (cnt_q == WOFF_W'(BLKWORDS - 1));

    // State, counters and LRU register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            way_q   <= 1'b0;
            flush_q <= 1'b0;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            way_q   <= way_d;
            flush_q <= flush_d;
            lru_q   <= lru_d;
        end
    end

    // Next state, array writes and bus outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        way_d    = way_q;
        flush_d  = flush_q;
        lru_d    = lru_q;
        we_data  = '0;
        we_meta  = '0;
        wdata    = dmemstore;
        wtag     = tag_w[way_q];
        wvalid   = valid_w[way_q];
        wdirty   = 1'b0;
        dhit     = 1'b0;
        dmemload = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        flushed  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_any && hit_any) begin
                    dhit           = 1'b1;
                    lru_d[req_idx] = ~hit_way;
                    if (dmemWEN) begin
                        we_data[hit_way] = 1'b1;
                        we_meta[hit_way] = 1'b1;
                        wtag             = req_tag;
                        wvalid           = 1'b1;
                        wdirty           = 1'b1;
                    end else begin
                        dmemload = rdata_w[hit_way];
                    end
                end else if (req_any) begin
                    idx_d   = req_idx;
                    way_d   = victim;
                    cnt_d   = '0;
                    flush_d = 1'b0;
                    state_d = (valid_w[victim] && dirty_w[victim]) ? WB : FETCH;
                end
                if (!(req_any && !hit_any) && halt) begin
                    state_d = FLUSH;
                    idx_d   = '0;
                    way_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(tag_w[way_q], idx_q, cnt_q);
                dstore = rdata_w[way_q];
                if (!dwait) begin
                    if (last_word) begin
                        cnt_d = '0;
                        if (flush_q) begin
                            // Block now matches memory; FLUSH revisits it as clean
                            we_meta[way_q] = 1'b1;
                            wdirty         = 1'b0;
                            state_d        = FLUSH;
                        end else begin
                            state_d = FETCH;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = blk_addr(req_tag, idx_q, cnt_q);
                if (!dwait) begin
                    we_data[way_q] = 1'b1;
                    wdata          = dload;
                    if (last_word) begin
                        we_meta[way_q] = 1'b1;
                        wtag           = req_tag;
                        wvalid         = 1'b1;
                        wdirty         = 1'b0;
                        cnt_d          = '0;
                        state_d        = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (valid_w[way_q] && dirty_w[way_q]) begin
                    cnt_d   = '0;
                    flush_d = 1'b1;
                    state_d = WB;
                end else if (way_q) begin
                    way_d = 1'b0;
                    if (idx_q == IDX_W'(SETS - 1)) state_d = DONE;
                    else                           idx_d   = idx_q + 1'b1;
                end else begin
                    way_d = 1'b1;
                end
            end
            DONE: begin
                flushed = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
